// File: rtl/adc_seq_pkg.sv
// adc_sequencer shared types
// State encoding and conversion-length helper
package adc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    SAMP   = 3'd2,
    COMP   = 3'd3,
    UPDATE = 3'd4
  } state_e;

  // busy cycles of one conversion: init + window + bit pairs
  function automatic int CONV_CYCLES(input int nbits,
                                     input int s);
    return 1 + s + 2 * nbits;
  endfunction

endpackage

// File: rtl/adc_sequencer.sv
// adc_sequencer: SAR ADC conversion strobe generator
// All strobes, busy, done and bit_idx are flop outputs
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NBITS  = 16,
  parameter int SAMP_W = 4,
  parameter int IDX_W  = $clog2(NBITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  input  logic [SAMP_W-1:0] samp_len,
  output logic              seq_init,
  output logic              seq_samp,
  output logic              seq_comp,
  output logic              seq_update,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  bit_idx
);

  state_e             state_q, state_d;
  logic [SAMP_W-1:0]  scnt_q, scnt_d;
  logic [IDX_W-1:0]   bit_q, bit_d;
  logic               done_q, done_d;
  logic               init_q, samp_q;
  logic               comp_q, upd_q, busy_q;

  // next state, down-counters and completion pulse
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // the done cycle doubles as a start slot in cont mode
          if (start || (cont && done_q)) begin
            state_d = INIT;
            scnt_d  = (samp_len == '0) ? SAMP_W'(1)
                                       : samp_len;
          end
        end
        INIT: state_d = SAMP;
        SAMP: begin
          if (scnt_q <= SAMP_W'(1)) begin
            state_d = COMP;
            bit_d   = IDX_W'(NBITS - 1);
          end else begin
            scnt_d = scnt_q - SAMP_W'(1);
          end
        end
        COMP: state_d = UPDATE;
        UPDATE: begin
          if (bit_q != '0) begin
            bit_d   = bit_q - IDX_W'(1);
            state_d = COMP;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          bit_d   = '0;
        end
      endcase
    end
  end

  // state and registered outputs decoded from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
      samp_q  <= 1'b0;
      comp_q  <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      init_q  <= (state_d == INIT);
      samp_q  <= (state_d == SAMP);
      comp_q  <= (state_d == COMP);
      upd_q   <= (state_d == UPDATE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign seq_init   = init_q;
  assign seq_samp   = samp_q;
  assign seq_comp   = comp_q;
  assign seq_update = upd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bit_idx    = bit_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// tb_adc_sequencer: directed and random checks
// against an offset-based conversion model
module tb_adc_sequencer;

  localparam int N  = 16;
  localparam int SW = 4;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst, start, cont, abort;
  logic [SW-1:0] samp_len;
  logic          seq_init, seq_samp, seq_comp, seq_update;
  logic          busy, done;
  logic [IW-1:0] bit_idx;

  adc_sequencer #(.NBITS(N), .SAMP_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont),
    .abort(abort), .samp_len(samp_len),
    .seq_init(seq_init), .seq_samp(seq_samp),
    .seq_comp(seq_comp), .seq_update(seq_update),
    .busy(busy), .done(done), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  int n_eval = 0;
  int n_fail = 0;

  // model: conversion active, offset k into it, window S
  bit m_act  = 1'b0;
  int m_k    = 0;
  int m_s    = 1;
  bit m_done = 1'b0;

  int busy_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_eval++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    if (rst || abort) begin
      m_act  = 1'b0;
      m_done = 1'b0;
    end else if (m_act) begin
      if (m_k == m_s + 2 * N) begin
        m_act  = 1'b0;
        m_done = 1'b1;
      end else begin
        m_k++;
        m_done = 1'b0;
      end
    end else if (start || (cont && m_done)) begin
      m_act  = 1'b1;
      m_k    = 0;
      m_s    = (samp_len == '0) ? 1 : int'(samp_len);
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic check_all();
    bit e_init, e_samp, e_comp, e_upd;
    int p, e_bit;
    p      = m_k - m_s - 1;
    e_init = m_act && (m_k == 0);
    e_samp = m_act && (m_k >= 1) && (m_k <= m_s);
    e_comp = m_act && (p >= 0) && (p % 2 == 0);
    e_upd  = m_act && (p >= 0) && (p % 2 == 1);
    e_bit  = (e_comp || e_upd) ? (N - 1 - p / 2) : 0;
    chk("seq_init",   32'(seq_init),   32'(e_init));
    chk("seq_samp",   32'(seq_samp),   32'(e_samp));
    chk("seq_comp",   32'(seq_comp),   32'(e_comp));
    chk("seq_update", 32'(seq_update), 32'(e_upd));
    chk("busy",       32'(busy),       32'(m_act));
    chk("done",       32'(done),       32'(m_done));
    chk("bit_idx",    32'(bit_idx),    32'(e_bit));
    chk("onehot",
        32'($countones({seq_init, seq_samp,
                        seq_comp, seq_update}) <= 1),
        32'(1));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic run_conv(input string tag,
                          input int sl,
                          input int exp_busy);
    samp_len = SW'(sl);
    start    = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    tick();
    start    = 1'b0;
    samp_len = SW'($urandom);
    repeat (exp_busy + 3) tick();
    chk({tag, "_busy"}, 32'(busy_cnt), 32'(exp_busy));
    chk({tag, "_done"}, 32'(done_cnt), 32'(1));
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    cont     = 1'b0;
    abort    = 1'b0;
    samp_len = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // basic lengths: S=4, S=0 (as 1), S=15
    run_conv("len4",  4,  37);
    run_conv("len0",  0,  34);
    run_conv("len15", 15, 48);

    // continuous: three conversions, cont dropped in third
    samp_len = SW'(2);
    cont     = 1'b1;
    start    = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    tick();
    start = 1'b0;
    repeat (79) tick();
    cont = 1'b0;
    repeat (60) tick();
    chk("cont_done", 32'(done_cnt), 32'(3));
    chk("cont_busy", 32'(busy_cnt), 32'(105));

    // start pulses while busy are ignored
    samp_len = SW'(4);
    start    = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    chk("ign_done", 32'(done_cnt), 32'(1));
    chk("ign_busy", 32'(busy_cnt), 32'(37));

    // abort in COMP, then a full conversion
    samp_len = SW'(4);
    start    = 1'b1;
    done_cnt = 0;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("pre_abort_comp", 32'(seq_comp), 32'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 32'(busy), 32'(0));
    run_conv("post_abort", 4, 37);

    // abort and start together in IDLE
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    tick();
    chk("abort_start", 32'(busy), 32'(0));

    // rst mid-conversion, then restart
    samp_len = SW'(4);
    start    = 1'b1;
    done_cnt = 0;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'(0));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_restart", 32'(seq_init), 32'(1));
    repeat (40) tick();
    chk("rst_done", 32'(done_cnt), 32'(1));

    // random traffic checked cycle by cycle
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom % 8) == 0;
      cont     = ($urandom % 4) == 0;
      abort    = ($urandom % 60) == 0;
      rst      = ($urandom % 250) == 0;
      samp_len = SW'($urandom);
      tick();
    end
    rst   = 1'b0;
    start = 1'b0;
    cont  = 1'b0;
    abort = 1'b0;
    repeat (60) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_eval, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_sequencer.md
Name: adc_sequencer

Overview:
- Generates the conversion timing strobes `seq_init`, `seq_samp`, `seq_comp` and `seq_update` for the SAR ADC.
- These strobes feed the clock-gate block, which ANDs them with the `en_*` enables to form the gated control clocks.
- One conversion is: one DAC-init cycle, a programmable sampling window, then NBITS comparator/update cycle pairs, MSB first.
- Runs in single-shot or continuous mode.

Parameters:
- NBITS, 16, number of bit-decision cycles per conversion (≥2).
- SAMP_W, 4, width of the `samp_len` input.
- IDX_W, $clog2(NBITS), width of `bit_idx`.

Ports:
- clk  in  1  sequencer clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a conversion; ignored while busy=1.
- cont  in  1  continuous mode; level, evaluated at end of conversion.
- abort  in  1  synchronous abort; returns to IDLE.
- samp_len  in  SAMP_W  sampling window length in cycles; captured at start; 0 is treated as 1.
- seq_init  out  1  DAC initialization strobe.
- seq_samp  out  1  sampling window.
- seq_comp  out  1  comparator strobe.
- seq_update  out  1  DAC update-logic strobe.
- busy  out  1  high from the first seq_init cycle through the last seq_update cycle.
- done  out  1  one-cycle pulse when a conversion completes.
- bit_idx  out  IDX_W  current bit index; NBITS-1 down to 0; valid while seq_comp or seq_update is high; 0 otherwise.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: all outputs are registered and reset to 0; state=IDLE.
- States: IDLE, INIT, SAMP, COMP, UPDATE.
- Exclusivity: at most one seq_* output is high in any cycle. There is no overlap and no glitch, because every seq_* is a flop output.
- IDLE: start=1 at edge t → INIT during cycle t+1. samp_len is latched at edge t.
- INIT: seq_init=1 for exactly 1 cycle → SAMP.
- SAMP: seq_samp=1 for max(samp_len,1) cycles; a down-counter is loaded from the latched value → COMP with bit_idx=NBITS-1.
- COMP: seq_comp=1 for 1 cycle → UPDATE with the same bit_idx.
- UPDATE: seq_update=1 for 1 cycle.
  - If bit_idx≠0: bit_idx decrements and the FSM goes to COMP.
  - Otherwise it goes to IDLE.
- done: asserted in the cycle following the last UPDATE, with busy=0 in that cycle.
- Conversion length: 1 + S + 2·NBITS cycles of busy, where S = max(samp_len,1).
- Continuous mode: if cont=1 in the done cycle, that cycle counts as a start (samp_len is re-latched) and seq_init follows the next cycle. The inter-conversion gap is exactly 1 cycle.
- start while busy is ignored and not queued. start in the done cycle behaves identically to cont=1.
- abort=1 in any non-IDLE state: next cycle is IDLE, all seq_* are 0, busy=0, no done pulse. Abort has priority over state progression.
- start and abort together in IDLE: abort wins and nothing starts.
- Changes to samp_len during a conversion have no effect.
- rst mid-conversion: next cycle matches the reset state, and no done pulse is issued.
- Counters never wrap: the bit counter stops at 0 and the sample counter stops at 1.

Decomposition:
- Package adc_seq_pkg holds:
  - the state enum (IDLE, INIT, SAMP, COMP, UPDATE), 3-bit encoding;
  - localparam helper CONV_CYCLES(NBITS, S).
- Single module; no sub-module is needed. The two down-counters are inline.

Test Plan:
1. Basic conversion (NBITS=16, samp_len=4, start at cycle 0):
   - seq_init at cycle 1; seq_samp cycles 2–5.
   - seq_comp on even cycles 6..36, seq_update on odd cycles 7..37; bit_idx goes 15→0.
   - done at cycle 38; busy at cycles 1–37.
2. samp_len=0 → seq_samp held exactly 1 cycle; total busy = 34 cycles. samp_len=15 → busy = 48 cycles.
3. Continuous mode (cont=1, samp_len=2): conversions back-to-back.
   - done at cycle 36 and seq_init at cycle 37.
   - Three conversions are completed, and the fourth does not start after cont is dropped before the third done.
4. start pulses at cycles 5 and 20 during a conversion are ignored; exactly one done pulse occurs. An assertion checks that at most one seq_* is high every cycle.
5. abort at cycle 10 (in COMP) → cycle 11 is IDLE with all outputs 0 and no done. A start at cycle 12 runs a full normal conversion.
6. rst asserted at cycle 20 for 1 cycle → all outputs 0 from cycle 21. A start at cycle 22 produces seq_init at cycle 23.
